// File: rtl/cache_mem_arbiter.sv
// Registered arbiter sharing the single axi_interface cache port between i_cache refill and d_cache load/store.
// Optional round-robin tie-break under CACHE_ARB_RR_EN; default build is fixed D-over-I priority.
module cache_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          i_req,
  input  logic          i_lock,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic          d_write,
  input  logic [1:0]    d_size,
  input  logic [3:0]    d_sel,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [AW-1:0] mem_a,
  output logic          mem_access,
  output logic          mem_write,
  output logic [1:0]    mem_size,
  output logic [3:0]    mem_sel,
  output logic [DW-1:0] mem_st_data,
  input  logic          mem_ready,
  output logic          grant_i
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  state_e state_q, state_d;
  logic   abort_q, abort_d;
  logic   owner_req, owner_lock;
  logic   d_wins;

  assign owner_req  = (state_q == GNT_D) ? d_req  : i_req;
  assign owner_lock = (state_q == GNT_D) ? d_lock : i_lock;

`ifdef CACHE_ARB_RR_EN
  // last_owner_q: 0 = instruction side, 1 = data side.
  logic last_owner_q, last_owner_d;

  assign d_wins = ~last_owner_q;

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q != IDLE && state_d == IDLE) last_owner_d = (state_q == GNT_D);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) last_owner_q <= 1'b0;
    else          last_owner_q <= last_owner_d;
  end
`else
  assign d_wins = 1'b1;
`endif

  // abort_q remembers an owner that dropped req mid-beat, so the grant never extends past that beat.
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (d_req && (!i_req || d_wins)) state_d = GNT_D;
        else if (i_req)                  state_d = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          abort_d = 1'b0;
          state_d = (owner_lock && owner_req && !abort_q) ? state_q : IDLE;
        end else if (!owner_req) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  // Outputs decode from state only; requests never reach mem_access combinationally.
  always_comb begin
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    grant_i     = 1'b0;
    mem_access  = 1'b0;
    mem_write   = 1'b0;
    mem_size    = 2'b00;
    mem_sel     = 4'h0;
    mem_a       = '0;
    mem_st_data = '0;
    case (state_q)
      GNT_I: begin
        grant_i    = 1'b1;
        mem_access = 1'b1;
        mem_size   = 2'b10;
        mem_sel    = 4'hF;
        mem_a      = i_addr;
        i_ready    = mem_ready;
      end
      GNT_D: begin
        mem_access  = 1'b1;
        mem_a       = d_addr;
        mem_write   = d_write;
        mem_size    = d_size;
        mem_sel     = d_sel;
        mem_st_data = d_wdata;
        d_ready     = mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected beats queued at stimulus, checked on each mem_ready beat.
module tb_cache_mem_arbiter;

  logic        aclk, aresetn;
  logic        i_req, i_lock, i_ready;
  logic [31:0] i_addr;
  logic        d_req, d_lock, d_write, d_ready;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [3:0]  d_sel;
  logic [31:0] mem_a, mem_st_data;
  logic        mem_access, mem_write, mem_ready, grant_i;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;

  cache_mem_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_lock(i_lock), .i_addr(i_addr), .i_ready(i_ready),
    .d_req(d_req), .d_lock(d_lock), .d_addr(d_addr), .d_write(d_write),
    .d_size(d_size), .d_sel(d_sel), .d_wdata(d_wdata), .d_ready(d_ready),
    .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .grant_i(grant_i)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        gi;
    logic [31:0] a;
    logic        w;
    logic [1:0]  sz;
    logic [3:0]  sel;
    logic [31:0] wd;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_beat(input logic gi, input logic [31:0] a, input logic w,
                           input logic [1:0] sz, input logic [3:0] sel, input logic [31:0] wd);
    beat_t b;
    b.gi = gi; b.a = a; b.w = w; b.sz = sz; b.sel = sel; b.wd = wd;
    exp_q.push_back(b);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Waits for any grant, holds mem_ready low dly cycles, completes one beat, drops the owner's request.
  task automatic serve(input int dly);
    int   n;
    logic g;
    n = 0;
    while (!mem_access && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      check_eq("grant_timeout", 1'b0, 1'b1);
    end else begin
      repeat (dly) step();
      g = grant_i;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      if (g) begin i_req = 1'b0; i_lock = 1'b0; end
      else   begin d_req = 1'b0; d_lock = 1'b0; end
      check_eq("turnaround_idle", mem_access, 1'b0);
    end
  endtask

  always @(negedge aclk) begin
    if (aresetn && mem_access && mem_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_beat", 1'b1, 1'b0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check_eq("beat_grant_i", grant_i, e.gi);
        check_eq("beat_addr", mem_a, e.a);
        check_eq("beat_write", mem_write, e.w);
        check_eq("beat_size", mem_size, e.sz);
        check_eq("beat_sel", mem_sel, e.sel);
        check_eq("beat_wdata", mem_st_data, e.wd);
        check_eq("beat_ready", {i_ready, d_ready}, e.gi ? 2'b10 : 2'b01);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0; mem_ready = 1'b0;
    i_req = 1'b0; i_lock = 1'b0; i_addr = '0;
    d_req = 1'b0; d_lock = 1'b0; d_addr = '0; d_write = 1'b0;
    d_size = '0; d_sel = '0; d_wdata = '0;
    #12;
    check_eq("rst_access", mem_access, 1'b0);
    check_eq("rst_grant_i", grant_i, 1'b0);
    check_eq("rst_readies", {i_ready, d_ready}, 2'b00);
    check_eq("rst_mem_a", mem_a, 32'h0);
    #1 aresetn = 1'b1;

    // Single instruction fetch: exact one-cycle grant latency.
    step();
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    push_beat(1'b1, 32'hBFC0_0000, 1'b0, 2'b10, 4'hF, 32'h0);
    @(negedge aclk);
    check_eq("s1_idle_before", mem_access, 1'b0);
    step();
    @(negedge aclk);
    check_eq("s1_grant_i", grant_i, 1'b1);
    check_eq("s1_access", mem_access, 1'b1);
    check_eq("s1_addr", mem_a, 32'hBFC0_0000);
    check_eq("s1_sel", mem_sel, 4'hF);
    check_eq("s1_size", mem_size, 2'b10);
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; i_req = 1'b0;
    @(negedge aclk);
    check_eq("s1_idle_after", mem_access, 1'b0);
    check_eq("s1_iready_low", i_ready, 1'b0);

    // Simultaneous requests, last owner is I: D first in both builds.
    step();
    i_req = 1'b1; i_addr = 32'hBFC0_0004;
    d_req = 1'b1; d_addr = 32'h8000_1000; d_write = 1'b1; d_size = 2'b01;
    d_sel = 4'h3; d_wdata = 32'h0000_1234;
    push_beat(1'b0, 32'h8000_1000, 1'b1, 2'b01, 4'h3, 32'h0000_1234);
    push_beat(1'b1, 32'hBFC0_0004, 1'b0, 2'b10, 4'hF, 32'h0);
    serve(1);
    serve(0);

    // Locked 4-beat refill with d_req pending throughout.
    step();
    i_req = 1'b1; i_lock = 1'b1; i_addr = 32'h0040_0000;
    for (int b = 0; b < 4; b++) push_beat(1'b1, 32'h0040_0000 + 32'(4 * b), 1'b0, 2'b10, 4'hF, 32'h0);
    step();
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h8000_2000; d_size = 2'b10;
    d_sel = 4'hF; d_wdata = 32'h0;
    push_beat(1'b0, 32'h8000_2000, 1'b0, 2'b10, 4'hF, 32'h0);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) begin
        if (b == 3 && k == 2) i_lock = 1'b0;
        mem_ready = (k == 2);
        @(negedge aclk);
        check_eq("refill_access", mem_access, 1'b1);
        check_eq("refill_grant_i", grant_i, 1'b1);
        step();
        mem_ready = 1'b0;
        if (k == 2) i_addr = i_addr + 32'd4;
      end
    end
    i_req = 1'b0;
    check_eq("refill_turnaround", mem_access, 1'b0);
    serve(0);

    // Simultaneous requests with last owner D.
    step();
    i_req = 1'b1; i_addr = 32'h0040_0100;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h8000_1800; d_size = 2'b00;
    d_sel = 4'h4; d_wdata = 32'h00AB_0000;
`ifdef CACHE_ARB_RR_EN
    push_beat(1'b1, 32'h0040_0100, 1'b0, 2'b10, 4'hF, 32'h0);
    push_beat(1'b0, 32'h8000_1800, 1'b1, 2'b00, 4'h4, 32'h00AB_0000);
`else
    push_beat(1'b0, 32'h8000_1800, 1'b1, 2'b00, 4'h4, 32'h00AB_0000);
    push_beat(1'b1, 32'h0040_0100, 1'b0, 2'b10, 4'hF, 32'h0);
`endif
    serve(0);
    serve(2);

    // Flush: d_req drops a cycle before mem_ready while d_lock stays high.
    step();
    d_req = 1'b1; d_lock = 1'b1; d_write = 1'b0; d_addr = 32'h8000_3000;
    d_size = 2'b00; d_sel = 4'h1; d_wdata = 32'h0;
    push_beat(1'b0, 32'h8000_3000, 1'b0, 2'b00, 4'h1, 32'h0);
    step();
    @(negedge aclk);
    check_eq("flush_access", mem_access, 1'b1);
    step();
    d_req = 1'b0;
    @(negedge aclk);
    check_eq("flush_hold", mem_access, 1'b1);
    step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    @(negedge aclk);
    check_eq("flush_idle", mem_access, 1'b0);
    d_lock = 1'b0;

    // Asynchronous reset mid-GNT_D.
    step();
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h8000_4000; d_size = 2'b10;
    d_sel = 4'hF; d_wdata = 32'hCAFE_0001;
    step();
    @(negedge aclk);
    check_eq("rstmid_access", mem_access, 1'b1);
    step();
    mem_ready = 1'b1;
    #1 aresetn = 1'b0;
    #1;
    check_eq("rstmid_access_low", mem_access, 1'b0);
    check_eq("rstmid_write_low", mem_write, 1'b0);
    check_eq("rstmid_dready_low", d_ready, 1'b0);
    check_eq("rstmid_addr_zero", mem_a, 32'h0);
    check_eq("rstmid_wdata_zero", mem_st_data, 32'h0);
    check_eq("rstmid_sel_size", {mem_sel, mem_size}, 6'h0);
    mem_ready = 1'b0;
    #1 aresetn = 1'b1;
    #1;
    check_eq("rstmid_idle_gap", mem_access, 1'b0);
    push_beat(1'b0, 32'h8000_4000, 1'b1, 2'b10, 4'hF, 32'hCAFE_0001);
    serve(0);

    // Spurious mem_ready in IDLE.
    step();
    mem_ready = 1'b1;
    @(negedge aclk);
    check_eq("spur_readies", {i_ready, d_ready}, 2'b00);
    check_eq("spur_access", mem_access, 1'b0);
    step();
    mem_ready = 1'b0;
    @(negedge aclk);
    check_eq("spur_stays_idle", mem_access, 1'b0);

    check_eq("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
